// File: rtl/direction_ctrl_pkg.sv
// Shared definitions for the direction input stage: direction codes,
// the reversal test and the default debounce length.
package direction_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // 10 ms at 25 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

  // Codes were chosen so that opposite headings differ only in bit 1.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage : direction_ctrl_pkg

// File: rtl/direction_ctrl_button_debounce.sv
// One button: two-flop synchroniser, hold-time debounce counter, stable
// level and a one-cycle pulse on each accepted press (stable 1 -> 0).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic VGA_clk,
  input  logic reset,
  input  logic btn_n,
  output logic stable_n,
  output logic press
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Debounce next state: restart whenever the synchronised level agrees
  // with the accepted one, accept it after DEBOUNCE_CYCLES disagreeing cycles.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      press_d  = stable_q;  // only the 1 -> 0 transition is a press
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser and debounce state; released buttons read as 1.
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the two synchroniser stages distinct flops.
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign stable_n = stable_q;
  assign press    = press_q;

endmodule : button_debounce

// File: rtl/direction_ctrl.sv
// Direction input stage: debounces four buttons, queues the latest press
// and commits it on the game's update tick, refusing 180-degree reversals.
module direction_ctrl
  import direction_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 18
) (
  input  logic VGA_clk,
  input  logic reset,
  input  logic btn_up_n,
  input  logic btn_left_n,
  input  logic btn_down_n,
  input  logic btn_right_n,
  input  logic update,
  input  logic clear,
  output logic up,
  output logic left,
  output logic down,
  output logic right
);

  // Bit index of each vector equals the direction code.
  logic [3:0] btn_n_w;
  logic [3:0] press_w;

  assign btn_n_w = {btn_right_n, btn_down_n, btn_left_n, btn_up_n};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .VGA_clk (VGA_clk),
      .reset   (reset),
      .btn_n   (btn_n_w[g]),
      .stable_n(),
      .press   (press_w[g])
    );
  end

  dir_t       cur_q, cur_d;
  dir_t       pending_q, pending_d;
  logic       pending_valid_q, pending_valid_d;
  logic       moving_q, moving_d;
  logic [3:0] dir_n_q, dir_n_d;

  // Heading and request queue: clear wins, then the update commits the old
  // request, then a fresh press (lowest code wins) becomes the new request.
  always_comb begin
    cur_d           = cur_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    moving_d        = moving_q;
    if (clear) begin
      moving_d        = 1'b0;
      pending_valid_d = 1'b0;
    end else begin
      if (update && pending_valid_q) begin
        if (!(moving_q && is_opposite(pending_q, cur_q))) begin
          cur_d    = pending_q;
          moving_d = 1'b1;
        end
        pending_valid_d = 1'b0;
      end
      for (int i = 3; i >= 0; i--) begin
        if (press_w[i]) begin
          pending_d       = dir_t'(2'(i));
          pending_valid_d = 1'b1;
        end
      end
    end
    dir_n_d = moving_d ? ~(4'b0001 << cur_d) : 4'b1111;
  end

  // Registered state and active-low outputs.
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      cur_q           <= DIR_UP;
      pending_q       <= DIR_UP;
      pending_valid_q <= 1'b0;
      moving_q        <= 1'b0;
      dir_n_q         <= 4'b1111;
    end else begin
      cur_q           <= cur_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      moving_q        <= moving_d;
      dir_n_q         <= dir_n_d;
    end
  end

  assign up    = dir_n_q[DIR_UP];
  assign left  = dir_n_q[DIR_LEFT];
  assign down  = dir_n_q[DIR_DOWN];
  assign right = dir_n_q[DIR_RIGHT];

endmodule : direction_ctrl

// File: tb/tb_direction_ctrl.sv
// Bench for direction_ctrl with a short debounce: directed scenarios plus a
// randomized phase, all compared against a behavioural model every cycle.
module tb_direction_ctrl;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] bn;        // index = direction code (0 up, 1 left, 2 down, 3 right)
  logic       update, clear;
  logic       up, left, down, right;
  logic [3:0] outs;

  assign outs = {right, down, left, up};

  always #5 clk = ~clk;

  direction_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .VGA_clk    (clk),
    .reset      (reset),
    .btn_up_n   (bn[0]),
    .btn_left_n (bn[1]),
    .btn_down_n (bn[2]),
    .btn_right_n(bn[3]),
    .update     (update),
    .clear      (clear),
    .up         (up),
    .left       (left),
    .down       (down),
    .right      (right)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_seen1[4], m_seen2[4];  // raw samples of the last two edges
  int m_run[4];                // consecutive edges the sampled level disagreed
  bit m_stab[4];
  bit m_prs[4];                // press accepted at the previous edge
  int m_head, m_pend;
  bit m_moving, m_pv;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_seen1[b] = 1; m_seen2[b] = 1; m_run[b] = 0; m_stab[b] = 1; m_prs[b] = 0;
    end
    m_head = 0; m_pend = 0; m_moving = 0; m_pv = 0;
  endtask

  function automatic logic [3:0] model_outs();
    return m_moving ? (4'hF & ~(4'h1 << m_head)) : 4'hF;
  endfunction

  task automatic model_step();
    bit seen;
    int first;
    if (reset) begin
      model_reset();
      return;
    end
    // heading / request queue, using presses accepted at the previous edge
    if (clear) begin
      m_moving = 0; m_pv = 0;
    end else begin
      if (update && m_pv) begin
        if (!(m_moving && ((m_head + 2) % 4 == m_pend))) begin
          m_head = m_pend; m_moving = 1;
        end
        m_pv = 0;
      end
      first = -1;
      for (int b = 0; b < 4; b++) if (m_prs[b] && first < 0) first = b;
      if (first >= 0) begin m_pend = first; m_pv = 1; end
    end
    // debounce: level seen now is the raw value from two edges ago
    for (int b = 0; b < 4; b++) begin
      seen = m_seen2[b];
      m_seen2[b] = m_seen1[b];
      m_seen1[b] = bn[b];
      m_prs[b] = 0;
      if (seen == m_stab[b]) m_run[b] = 0;
      else begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          m_prs[b]  = m_stab[b];
          m_stab[b] = seen;
          m_run[b]  = 0;
        end
      end
    end
  endtask

  // One clock: inputs are set before the call (at a negedge), outputs checked
  // at the following negedge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outs_vs_model", 32'(outs), 32'(model_outs()));
  endtask

  task automatic press(input int b);
    bn[b] = 1'b0; repeat (DC + 4) step();
    bn[b] = 1'b1; repeat (DC + 4) step();
  endtask

  task automatic pulse_update();
    update = 1'b1; step();
    update = 1'b0; step();
  endtask

  // Count cycles until output idx goes low; -1 if the budget runs out.
  task automatic wait_low(input int idx, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (outs[idx] == 1'b0) begin n = k; break; end
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; bn = 4'hF; update = 1'b0; clear = 1'b0;
    model_reset();
    @(negedge clk);
    step(); step();
    check("reset_outs", 32'(outs), 32'hF);
    reset = 1'b0;

    // no presses, 20 updates: stay idle
    for (int i = 0; i < 20; i++) begin
      pulse_update();
      check("idle_update", 32'(outs), 32'hF);
    end

    // bouncing left, then held: press 6 edges after the last fall,
    // queued at 7, committed at 8 with update held high
    for (int i = 0; i < 5; i++) begin
      bn[1] = 1'b0; step(); step();
      bn[1] = 1'b1; step(); step();
    end
    bn[1] = 1'b0; update = 1'b1;
    wait_low(1, 20, n);
    check("left_latency", 32'(n), 32'd8);
    update = 1'b0; step();
    check("left_moving", 32'(outs), 32'b1101);
    bn[1] = 1'b1; repeat (DC + 4) step();

    // reach RIGHT via UP, then reversal LEFT is rejected
    press(0); pulse_update();
    check("turn_up", 32'(outs), 32'b1110);
    press(3); pulse_update();
    check("turn_right", 32'(outs), 32'b0111);
    press(1); pulse_update();
    check("reverse_rejected", 32'(outs), 32'b0111);
    pulse_update();
    check("pending_cleared", 32'(outs), 32'b0111);

    // last press wins
    press(0); press(2); pulse_update();
    check("last_press_wins", 32'(outs), 32'b1011);

    // stop, then simultaneous up+right: up has priority, accepted while stopped
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_stops", 32'(outs), 32'hF);
    bn[0] = 1'b0; bn[3] = 1'b0; repeat (DC + 4) step();
    bn[0] = 1'b1; bn[3] = 1'b1; repeat (DC + 4) step();
    pulse_update();
    check("priority_up", 32'(outs), 32'b1110);

    // moving DOWN, clear together with update and a pending LEFT
    clear = 1'b1; step(); clear = 1'b0;
    press(2); pulse_update();
    check("turn_down", 32'(outs), 32'b1011);
    press(1);
    clear = 1'b1; update = 1'b1; step();
    clear = 1'b0; update = 1'b0;
    check("clear_over_update", 32'(outs), 32'hF);
    pulse_update();
    check("clear_dropped_pending", 32'(outs), 32'hF);

    // reset mid-debounce with down held: fresh press after release
    bn[2] = 1'b0; repeat (3) step();
    reset = 1'b1; #1;
    model_reset();
    check("async_reset", 32'(outs), 32'hF);
    @(negedge clk);
    step(); step();
    reset = 1'b0; update = 1'b1;
    wait_low(2, 20, n);
    check("down_after_reset", 32'(n), 32'd8);
    update = 1'b0;
    bn[2] = 1'b1; repeat (DC + 4) step();

    // randomized bouncing buttons, updates, clears and rare resets
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) bn[b] = ~bn[b];
      update = ($urandom_range(0, 5) == 0);
      clear  = ($urandom_range(0, 59) == 0);
      reset  = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; update = 1'b0; clear = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_direction_ctrl

// File: doc/direction_ctrl.md
Name: direction_ctrl

Overview:
- Input stage that turns the four raw, bouncing, active-low direction buttons into the registered, active-low, at-most-one-low direction levels that the snake game core consumes on its `up`/`left`/`down`/`right` inputs.
- Synchronises and debounces each button, and queues the most recent press.
- Commits the queued press only on the game's `update` tick, so there is at most one turn per snake step.
- Rejects 180° reversals.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles a synchronised button level must hold before it is accepted (10 ms at 25 MHz).
- CNT_W, 18, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- VGA_clk  in  1  25 MHz pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- btn_up_n  in  1  raw up button, active low, asynchronous to VGA_clk.
- btn_left_n  in  1  raw left button, active low.
- btn_down_n  in  1  raw down button, active low.
- btn_right_n  in  1  raw right button, active low.
- update  in  1  one-cycle step pulse from the game tick generator.
- clear  in  1  synchronous stop request (game over/restart); level-sensitive.
- up  out  1  active low, registered; low = moving up.
- left  out  1  active low, registered.
- down  out  1  active low, registered.
- right  out  1  active low, registered.

Behaviour:
- Clock and reset: one clock, VGA_clk; reset is asynchronous and active-high.
- Reset state:
  - synchroniser flops = 1.
  - stable levels = 1.
  - counters = 0.
  - pending_valid = 0.
  - cur = UP.
  - moving = 0.
  - up/left/down/right = 1 (no movement).
- Synchroniser: two flops per button; later logic sees only the second-stage value.
- Debounce, per button:
  - sync == stable: count <= 0.
  - Otherwise count increments.
  - When count == DEBOUNCE_CYCLES-1: stable <= sync and count <= 0.
  - Total latency from a clean edge to a stable change = 2 + DEBOUNCE_CYCLES cycles.
- Press event: one-cycle pulse when stable goes 1->0. Releases generate nothing.
- Direction codes: UP=0, LEFT=1, DOWN=2, RIGHT=3. Two codes are opposite when code_a XOR code_b == 2'b10.
- Pending request:
  - Any press event: pending <= code, pending_valid <= 1.
  - A later press overwrites an earlier one (last press wins).
  - Several press events in the same cycle: priority UP > LEFT > DOWN > RIGHT.
- Commit, on update==1 with pending_valid==1:
  - moving==1 and pending is opposite to cur: discard the request; cur unchanged.
  - Otherwise: cur <= pending and moving <= 1.
  - pending_valid <= 0 in both cases.
- update with pending_valid==0: no change; the snake keeps its current heading.
- Press event in the same cycle as update:
  - The update commits the old pending value.
  - The new press becomes the pending value (pending_valid = 1 afterwards).
- clear==1, which has priority over update and press events:
  - moving <= 0 and pending_valid <= 0; press events that cycle are dropped.
  - cur is retained.
  - Debounce state is unaffected.
- Outputs:
  - Registered: up = ~(moving && cur==UP), and likewise for the other three.
  - Outputs change exactly 1 cycle after the committing update or the clear cycle.
  - Never more than one output is low.
- Reset asserted mid-debounce or mid-pending: everything returns to the reset state immediately; after release, a button already held low is debounced afresh and produces one press event.

Decomposition:
- Shared package:
  - dir_t, a 2-bit enum UP/LEFT/DOWN/RIGHT.
  - DIR_* constants.
  - function is_opposite(a,b).
  - DEBOUNCE_CYCLES default.
- Sub-module button_debounce, instantiated 4 times:
  - Contents: 2-flop synchroniser, counter, stable register, press pulse.
  - Ports: VGA_clk, reset, btn_n, stable_n, press.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset then no presses, 20 update pulses -> up/left/down/right stay 1111 throughout.
- btn_left_n toggles every 2 cycles for 20 cycles, then held low -> exactly one press event, 6 cycles after the final low edge; next update -> left=0, others 1, one cycle after update.
- Moving RIGHT, press LEFT, update -> right stays 0; pending cleared; next update with no press still RIGHT.
- Moving RIGHT, press UP then DOWN before the next update -> after update down=0 (last press wins).
- btn_up_n and btn_right_n fall in the same cycle, not moving -> after update up=0.
- Moving DOWN, clear for 1 cycle together with update and a pending LEFT -> outputs 1111 the next cycle; the following update leaves 1111.
- Reset asserted mid-debounce with btn_down_n held low -> after release, down press seen 6 cycles later.
